// File: rtl/fft_ctrl_pkg.sv
// Shared types and size constants for the radix-2 DIT FFT control path.
// The scheduler FSM encoding and the default transform size live here.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int LOG2N_DEF = 8;
    localparam int N         = 1 << LOG2N_DEF;
    localparam int HALF_N    = N / 2;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly address generator: (stage, index) -> operand
// addresses and twiddle ROM address for an in-place radix-2 DIT FFT.
module fft_bf_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int SW    = $clog2(LOG2N)
) (
    input  logic [SW-1:0]    s,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [LOG2N-2:0] tw
);

    localparam logic [LOG2N-1:0] ADDR_ONE  = LOG2N'(1);
    localparam logic [SW:0]      TW_SHIFT0 = (SW+1)'(LOG2N-1);

    logic [LOG2N-2:0] pos_mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-2:0] grp;
    logic [LOG2N-1:0] half;
    logic [SW:0]      tw_shift;

    // The operand pair is j with a zero bit inserted at position s; the
    // partner sits exactly one half-span above it.
    always_comb begin
        pos_mask = ~({(LOG2N-1){1'b1}} << s);
        pos      = j & pos_mask;
        grp      = j >> s;
        half     = ADDR_ONE << s;
        a        = (({1'b0, grp} << s) << 1) | {1'b0, pos};
        b        = a + half;
        tw_shift = TW_SHIFT0 - {1'b0, s};
        tw       = pos << tw_shift;
    end

endmodule

// File: rtl/fft_bf_scheduler.sv
// Stage/butterfly sequencer for the in-place radix-2 FFT: drives the twiddle
// ROM, presents one descriptor per handshake, and barriers between stages.
module fft_bf_scheduler
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int SW    = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-2:0] tw_addr,
    output logic             tw_addr_nd,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [SW-1:0]    bf_stage,
    output logic             bf_last,
    input  logic             bf_wr_ack
);

    localparam logic [LOG2N-2:0] J_LAST  = '1;
    localparam logic [LOG2N-2:0] J_ONE   = (LOG2N-1)'(1);
    localparam logic [SW-1:0]    S_LAST  = SW'(LOG2N-1);
    localparam logic [SW-1:0]    S_ONE   = SW'(1);
    localparam logic [LOG2N-1:0] OUT_ONE = LOG2N'(1);

    state_t           state;
    state_t           state_nxt;
    logic [SW-1:0]    s_cnt;
    logic [LOG2N-2:0] j_cnt;
    logic [LOG2N-1:0] outstanding;

    logic             issue;
    logic             accept;
    logic             drained;
    logic             j_at_last;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;

    fft_bf_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .s  (s_cnt),
        .j  (j_cnt),
        .a  (gen_a),
        .b  (gen_b),
        .tw (gen_tw)
    );

    assign accept    = bf_valid && bf_ready;
    assign issue     = (state == RUN) && (!bf_valid || bf_ready);
    assign j_at_last = (j_cnt == J_LAST);
    // A stage may only begin once every writeback of the previous one landed.
    assign drained   = !bf_valid && (outstanding == '0);

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign tw_addr    = gen_tw;
    assign tw_addr_nd = issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (issue && j_at_last) state_nxt = WAIT;
            WAIT: if (drained) state_nxt = (s_cnt == S_LAST) ? DONE : RUN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // j wraps to 0 by itself after the last butterfly of a stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt <= '0;
            j_cnt <= '0;
        end else begin
            if (issue) begin
                j_cnt <= j_cnt + J_ONE;
            end
            if ((state == WAIT) && drained) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + S_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf_valid  <= 1'b0;
            bf_addr_a <= '0;
            bf_addr_b <= '0;
            bf_stage  <= '0;
            bf_last   <= 1'b0;
        end else if (issue) begin
            bf_valid  <= 1'b1;
            bf_addr_a <= gen_a;
            bf_addr_b <= gen_b;
            bf_stage  <= s_cnt;
            bf_last   <= j_at_last;
        end else if (accept) begin
            bf_valid  <= 1'b0;
        end
    end

    // Accepted-but-not-written-back count; a stray ack at zero is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, bf_wr_ack})
                2'b10: outstanding <= outstanding + OUT_ONE;
                2'b01: if (outstanding != '0) outstanding <= outstanding - OUT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Scoreboard bench for fft_bf_scheduler: a ROM model, randomized ready and
// writeback-ack drivers, and an arithmetic reference of every descriptor.
module tb_fft_bf_scheduler;

    localparam int HALF  = 128;
    localparam int TOTAL = 8 * HALF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bf_ready = 1'b0;
    logic       bf_wr_ack = 1'b0;
    logic       busy, done, tw_addr_nd, bf_valid, bf_last;
    logic [6:0] tw_addr;
    logic [7:0] bf_addr_a, bf_addr_b;
    logic [2:0] bf_stage;
    logic [15:0] tf_out = 16'h0;

    logic [2:0] sp_s = 3'd0;
    logic [6:0] sp_j = 7'd0;
    logic [7:0] sp_a, sp_b;
    logic [6:0] sp_tw;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    typedef struct { int a; int b; int s; int last; int tw; } desc_t;
    typedef struct { int unsigned due; int s; } ack_t;
    desc_t exp_q[$];
    ack_t  ack_q[$];

    int ready_pct = 100;
    int k_min = 4;
    int k_max = 4;
    bit force_low = 0;
    bit hold_s2 = 0;
    bit spurious_ack = 0;
    bit s2_last_acc = 0;
    int issue_idx = 0;
    int acc_idx = 0;
    int ack_count = 0;
    int done_count = 0;
    int unsigned last_ack_cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned done_cyc = 0;

    fft_bf_scheduler #(.LOG2N(8), .SW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .tw_addr    (tw_addr),
        .tw_addr_nd (tw_addr_nd),
        .bf_valid   (bf_valid),
        .bf_ready   (bf_ready),
        .bf_addr_a  (bf_addr_a),
        .bf_addr_b  (bf_addr_b),
        .bf_stage   (bf_stage),
        .bf_last    (bf_last),
        .bf_wr_ack  (bf_wr_ack)
    );

    fft_bf_addr_gen #(.LOG2N(8), .SW(3)) u_spot (
        .s  (sp_s),
        .j  (sp_j),
        .a  (sp_a),
        .b  (sp_b),
        .tw (sp_tw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(input logic [6:0] t);
        return {9'h1A5, t};
    endfunction

    always @(posedge clk) if (tw_addr_nd) tf_out <= rom_word(tw_addr);

    // Butterfly idx of the whole transform, stage-major.
    function automatic desc_t model(input int idx);
        desc_t d;
        int s, j, half, pos;
        s = idx / HALF;
        j = idx % HALF;
        half = 1 << s;
        pos = j % half;
        d.s = s;
        d.a = (j / half) * 2 * half + pos;
        d.b = d.a + half;
        d.tw = pos * (HALF / half);
        d.last = (j == HALF - 1) ? 1 : 0;
        return d;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tw_addr_nd"}, tw_addr_nd, 0);
        check({tag, "_bf_valid"}, bf_valid, 0);
        check({tag, "_bf_last"}, bf_last, 0);
        check({tag, "_tw_addr"}, tw_addr, 0);
        check({tag, "_bf_addr_a"}, bf_addr_a, 0);
        check({tag, "_bf_addr_b"}, bf_addr_b, 0);
        check({tag, "_bf_stage"}, bf_stage, 0);
    endtask

    task automatic spot(input int s, input int j, input int a, input int b, input int tw);
        sp_s = 3'(s);
        sp_j = 7'(j);
        #1;
        check("spot_a", sp_a, a);
        check("spot_b", sp_b, b);
        check("spot_tw", sp_tw, tw);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (force_low) bf_ready = 1'b0;
            else bf_ready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bf_wr_ack = 1'b0;
            if (spurious_ack) begin
                bf_wr_ack = 1'b1;
            end else if (rst_n && ack_q.size() > 0 && ack_q[0].due <= cyc &&
                         !(hold_s2 && ack_q[0].s == 2)) begin
                bf_wr_ack = 1'b1;
                void'(ack_q.pop_front());
                ack_count++;
                last_ack_cyc = cyc;
            end
        end
    end

    // Monitor: issues, stalls, accepts and done, sampled on the falling edge.
    initial begin
        desc_t d;
        bit stalled;
        int pa, pb, ps, pl, pt;
        stalled = 0;
        pa = 0; pb = 0; ps = 0; pl = 0; pt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (tw_addr_nd) begin
                if (issue_idx >= TOTAL) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_overrun: issue number %0d, only %0d expected", issue_idx + 1, TOTAL);
                end else begin
                    d = model(issue_idx);
                    check("issue_tw_addr", tw_addr, d.tw);
                    if (issue_idx == 0) begin
                        check("first_issue_cycle", cyc, start_cyc + 1);
                    end else if (issue_idx % HALF == 0) begin
                        check("barrier_acks", ack_count, issue_idx);
                        check("barrier_issue_cycle", cyc, last_ack_cyc + 2);
                    end
                end
                issue_idx++;
            end
            if (bf_valid && !bf_ready) check("no_issue_while_stalled", tw_addr_nd, 0);
            if (stalled) begin
                check("hold_valid", bf_valid, 1);
                check("hold_a", bf_addr_a, pa);
                check("hold_b", bf_addr_b, pb);
                check("hold_stage", bf_stage, ps);
                check("hold_last", bf_last, pl);
                check("hold_tf_out", tf_out, pt);
            end
            stalled = bf_valid && !bf_ready;
            pa = bf_addr_a; pb = bf_addr_b; ps = bf_stage; pl = bf_last; pt = tf_out;
            if (bf_valid && bf_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_descriptor: a=%0d b=%0d stage=%0d, none expected", bf_addr_a, bf_addr_b, bf_stage);
                end else begin
                    d = exp_q.pop_front();
                    check("desc_a", bf_addr_a, d.a);
                    check("desc_b", bf_addr_b, d.b);
                    check("desc_stage", bf_stage, d.s);
                    check("desc_last", bf_last, d.last);
                    check("desc_tf_out", tf_out, rom_word(7'(d.tw)));
                    if (d.s == 2 && d.last == 1) s2_last_acc = 1;
                    ack_q.push_back('{due: cyc + $urandom_range(k_max, k_min), s: d.s});
                end
                acc_idx++;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("busy_during_done", busy, 1);
            end
        end
    end

    task automatic start_run(input int pct, input int kmin, input int kmax);
        ready_pct = pct;
        k_min = kmin;
        k_max = kmax;
        issue_idx = 0;
        acc_idx = 0;
        ack_count = 0;
        done_count = 0;
        s2_last_acc = 0;
        exp_q.delete();
        ack_q.delete();
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(model(i));
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        check("busy_before_start", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_cycle1", busy, 1);
        check("tw_addr_nd_cycle1", tw_addr_nd, 1);
        check("tw_addr_cycle1", tw_addr, 0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_count == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_count == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles, issues=%0d accepts=%0d", name, budget, issue_idx, acc_idx);
        end else begin
            #1;
            check({name, "_busy_after_done"}, busy, 0);
            repeat (3) @(posedge clk);
            #1;
            check({name, "_done_pulses"}, done_count, 1);
            check({name, "_accepts"}, acc_idx, TOTAL);
            check({name, "_issues"}, issue_idx, TOTAL);
            check({name, "_acks"}, ack_count, TOTAL);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        spot(0, 3, 6, 7, 0);
        spot(3, 5, 5, 13, 80);
        spot(3, 13, 21, 29, 80);
        spot(7, 127, 127, 255, 127);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        spurious_ack = 1;
        repeat (2) @(posedge clk);
        #1;
        spurious_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("idle");

        // Full-rate run with a fixed writeback latency of 4.
        start_run(100, 4, 4);
        @(posedge clk);
        #1;
        check("first_valid", bf_valid, 1);
        check("first_a", bf_addr_a, 0);
        check("first_b", bf_addr_b, 1);
        check("first_stage", bf_stage, 0);
        check("first_tf_out", tf_out, rom_word(7'd0));
        repeat (200) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("fullrate", 3000);
        check("fullrate_done_cycle", done_cyc, start_cyc + 1 + 8 * (HALF + 4 + 2));

        // Random backpressure plus a forced 5-cycle stall mid-stage.
        start_run(75, 1, 8);
        n = 0;
        while (issue_idx < 3 * HALF + 50 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        force_low = 1;
        repeat (5) @(negedge clk);
        force_low = 0;
        wait_done("backpressure", 8000);

        // Stage barrier: stage-2 writebacks withheld.
        hold_s2 = 1;
        start_run(100, 4, 4);
        n = 0;
        while (!s2_last_acc && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("barrier_reached_s2_end", s2_last_acc, 1);
        repeat (20) begin
            @(negedge clk);
            check("barrier_no_issue", tw_addr_nd, 0);
            check("barrier_no_valid", bf_valid, 0);
            check("barrier_busy", busy, 1);
        end
        check("barrier_acks_held", ack_count, 2 * HALF);
        hold_s2 = 0;
        wait_done("barrier", 3000);

        // Reset in the middle of stage 5, then a clean restart.
        start_run(100, 3, 3);
        n = 0;
        while (issue_idx <= 5 * HALF + 40 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("reached_s5_j40", issue_idx > 5 * HALF + 40, 1);
        #2;
        rst_n = 1'b0;
        ack_q.delete();
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        exp_q.delete();
        ack_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_run(90, 2, 5);
        wait_done("restart", 5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
